// File: rtl/disp_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package disp_scan_pkg;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  localparam int NDIG = 4;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_P0   = 2'd1;
  localparam logic [1:0] OWN_P1   = 2'd2;

  localparam int SHOW_CYC_DEF  = 11250;
  localparam int BLANK_CYC_DEF = 1250;
  localparam int HOLD_FR_DEF   = 250;

  // Digit k is a leading zero when it and every higher nibble is 0; digit 0 never is.
  function automatic logic lz_blank(input logic [15:0] f, input logic [1:0] k);
    logic z;
    z = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (i >= int'(k) && f[4*i +: 4] != 4'd0) z = 1'b0;
    end
    return z && (k != 2'd0);
  endfunction

endpackage

// File: rtl/disp_arb2.sv
// Two-requester display arbiter: combinational next-owner choice plus the
// per-owner frame counter (held) that enforces the minimum hold time.
module disp_arb2
  import disp_scan_pkg::*;
#(
  parameter int HOLD_FR = HOLD_FR_DEF
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       arb_en,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] owner,
  output logic [1:0] next_owner
);

  localparam int HW = $clog2(HOLD_FR + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FR);

  logic [HW-1:0] held;
  logic [HW-1:0] held_inc;
  logic          own_req;
  logic          oth_req;
  logic [1:0]    oth;

  // The frame that just ended counts toward the owner's hold before deciding.
  always_comb begin
    held_inc   = (held >= HOLD_MAX) ? held : held + 1'b1;
    own_req    = (owner == OWN_P0) ? req0 : req1;
    oth_req    = (owner == OWN_P0) ? req1 : req0;
    oth        = (owner == OWN_P0) ? OWN_P1 : OWN_P0;
    next_owner = OWN_NONE;
    if (owner == OWN_NONE)
      next_owner = req1 ? OWN_P1 : (req0 ? OWN_P0 : OWN_NONE);
    else if (!own_req)
      next_owner = oth_req ? oth : OWN_NONE;
    else if (oth_req && held_inc >= HOLD_MAX)
      next_owner = oth;
    else
      next_owner = owner;
  end

  always_ff @(posedge clk_sys) begin
    if (rst)
      held <= '0;
    else if (arb_en)
      held <= (next_owner == owner && owner != OWN_NONE) ? held_inc : '0;
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan controller for the shared 4-digit seven-segment display with a two-port arbiter.
// Optional build macro: DISP_LZ_BLANK_EN enables leading-zero suppression.
module disp_scan_ctrl
  import disp_scan_pkg::*;
#(
  parameter int SHOW_CYC  = SHOW_CYC_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF,
  parameter int HOLD_FR   = HOLD_FR_DEF
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [1:0]  dig_sel,
  output logic [3:0]  dig_val,
  output logic        blank,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

`ifdef DISP_LZ_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  localparam int SW = $clog2(SHOW_CYC + 1);
  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam int CW = (SW > BW) ? SW : BW;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  scan_state_e   state;
  logic [CW-1:0] cnt;
  logic [1:0]    owner;
  logic [1:0]    next_owner;
  logic [15:0]   frame_reg;
  logic [15:0]   snap;
  logic [1:0]    sel_nxt;

  function automatic logic [3:0] nib(input logic [15:0] f, input logic [1:0] k);
    return f[{k, 2'b00} +: 4];
  endfunction

  function automatic logic lit_blank(input logic [1:0] own, input logic [15:0] f,
                                     input logic [1:0] k);
    return (own == OWN_NONE) || (LZ_EN && lz_blank(f, k));
  endfunction

  // req/gnt: a requester holds req while it wants the display; gnt changes only
  // at frame boundaries, so a dropped req keeps its grant until the frame ends.
  disp_arb2 #(.HOLD_FR(HOLD_FR)) u_arb (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .arb_en     (state == ST_ARB),
    .req0       (req0),
    .req1       (req1),
    .owner      (owner),
    .next_owner (next_owner)
  );

  always_comb begin
    snap = 16'h0;
    if (next_owner == OWN_P0)      snap = data0;
    else if (next_owner == OWN_P1) snap = data1;
  end

  assign sel_nxt   = dig_sel + 2'd1;
  assign dbg_state = state;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state      <= ST_ARB;
      cnt        <= '0;
      owner      <= OWN_NONE;
      frame_reg  <= 16'h0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      dig_sel    <= 2'd0;
      dig_val    <= 4'd0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_ARB: begin
          owner     <= next_owner;
          gnt0      <= (next_owner == OWN_P0);
          gnt1      <= (next_owner == OWN_P1);
          frame_reg <= snap;
          dig_sel   <= 2'd0;
          dig_val   <= nib(snap, 2'd0);
          blank     <= lit_blank(next_owner, snap, 2'd0);
          cnt       <= '0;
          state     <= ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt   <= '0;
            blank <= 1'b1;
            state <= ST_BLANK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt <= '0;
            if (dig_sel == 2'(NDIG - 1)) begin
              dig_val    <= 4'd0;
              blank      <= 1'b1;
              frame_done <= 1'b1;
              state      <= ST_ARB;
            end else begin
              dig_sel <= sel_nxt;
              dig_val <= nib(frame_reg, sel_nxt);
              blank   <= lit_blank(owner, frame_reg, sel_nxt);
              state   <= ST_SHOW;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed scenarios plus random requests/data/resets,
// checked cycle by cycle against a frame-position reference model.
`timescale 1ns/1ps
module tb_disp_scan_ctrl;
  import disp_scan_pkg::*;

  localparam int S     = 8;
  localparam int B     = 2;
  localparam int H     = 2;
  localparam int DIG   = S + B;
  localparam int FRAME = 1 + 4 * DIG;

`ifdef DISP_LZ_BLANK_EN
  localparam bit LZ_ON = 1'b1;
`else
  localparam bit LZ_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk_sys = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] data0, data1;
  logic        gnt0, gnt1, blank, frame_done;
  logic [1:0]  dig_sel, dbg_state;
  logic [3:0]  dig_val;

  always #5 clk_sys = ~clk_sys;

  disp_scan_ctrl #(.SHOW_CYC(S), .BLANK_CYC(B), .HOLD_FR(H)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .data0      (data0),
    .data1      (data1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .dig_sel    (dig_sel),
    .dig_val    (dig_val),
    .blank      (blank),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_t counts cycles since reset; position in the frame fixes every output.
  int          m_t, m_owner, m_frames;
  logic [15:0] m_frame;

  function automatic logic [11:0] model_out();
    int pos = m_t % FRAME;
    int fr  = m_t / FRAME;
    int d, r;
    logic [1:0] st, sel;
    logic [3:0] val;
    logic bl, fd, lit;
    logic g0, g1;
    g0 = (m_owner == 1);
    g1 = (m_owner == 2);
    if (pos == 0) begin
      st  = ST_ARB;
      sel = (fr == 0) ? 2'd0 : 2'd3;
      val = 4'd0;
      bl  = 1'b1;
      fd  = (fr > 0);
    end else begin
      d   = (pos - 1) / DIG;
      r   = (pos - 1) % DIG;
      lit = (r < S);
      st  = lit ? ST_SHOW : ST_BLANK;
      sel = d[1:0];
      val = 4'(m_frame >> (4 * d));
      bl  = !lit || (m_owner == 0) || (LZ_ON && d > 0 && (m_frame >> (4 * d)) == 16'h0);
      fd  = 1'b0;
    end
    return {st, g0, g1, sel, val, bl, fd};
  endfunction

  task automatic arbitrate();
    int want, oth, shown;
    bit mine, other;
    shown = 0;
    if (m_owner == 0) begin
      want = req1 ? 2 : (req0 ? 1 : 0);
    end else begin
      mine  = (m_owner == 1) ? req0 : req1;
      other = (m_owner == 1) ? req1 : req0;
      oth   = 3 - m_owner;
      shown = (m_frames + 1 > H) ? H : m_frames + 1;
      if (!mine)                      want = other ? oth : 0;
      else if (other && shown >= H)   want = oth;
      else                            want = m_owner;
    end
    m_frames = (want != 0 && want == m_owner) ? shown : 0;
    m_owner  = want;
    m_frame  = (want == 2) ? data1 : ((want == 1) ? data0 : 16'h0);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_t = 0; m_owner = 0; m_frames = 0; m_frame = 16'h0;
    end else begin
      if (m_t % FRAME == 0) arbitrate();
      m_t++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: compare this cycle, advance the model across the next edge.
  task automatic tick();
    exp_q.push_back(model_out());
    check($sformatf("out@t%0d", m_t),
          32'({dbg_state, gnt0, gnt1, dig_sel, dig_val, blank, frame_done}),
          32'(exp_q.pop_front()));
    model_edge();
    @(negedge clk_sys);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 16'h0; data1 = 16'h0;
    m_t = 0; m_owner = 0; m_frames = 0; m_frame = 16'h0;
    @(posedge clk_sys);
    @(negedge clk_sys);

    // idle: blank throughout, frame_done at every ARB after the first
    do_reset();
    run(82);
    check("idle_frame_done", 32'(frame_done), 1);
    check("idle_gnt", 32'({gnt0, gnt1}), 0);
    check("idle_blank", 32'(blank), 1);

    // result owner, data change mid-frame
    req1 = 1'b1; data1 = 16'h1234;
    do_reset();
    run(1);
    check("res_gnt1", 32'(gnt1), 1);
    check("res_dig0", 32'(dig_val), 4);
    check("res_lit", 32'(blank), 0);
    run(12);
    data1 = 16'h5678;
    run(8);
    check("res_old_snap", 32'(dig_val), 2);
    run(21);
    check("res_new_snap", 32'(dig_val), 8);
    run(40);

    // both requesting: hold for two frames then alternate
    req0 = 1'b1; req1 = 1'b1; data0 = 16'h9876; data1 = 16'h1234;
    do_reset();
    run(83);
    check("alt_gnt0", 32'({gnt0, gnt1}), 32'h2);
    check("alt_val0", 32'(dig_val), 6);
    run(82);
    check("alt_gnt1", 32'({gnt0, gnt1}), 32'h1);

    // owner drops mid-frame with no competitor
    req0 = 1'b0; req1 = 1'b1; data1 = 16'h4321;
    do_reset();
    run(20);
    req1 = 1'b0;
    run(20);
    check("drop_held", 32'(gnt1), 1);
    run(2);
    check("drop_gnt", 32'({gnt0, gnt1}), 0);
    check("drop_blank", 32'(blank), 1);
    run(41);

    // sparse value, then reset mid digit 2
    req1 = 1'b1; data1 = 16'h0050;
    do_reset();
    run(12);
    check("sparse_dig1", 32'(dig_val), 5);
    check("sparse_lit1", 32'(blank), 0);
    run(13);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_gnt", 32'({gnt0, gnt1}), 0);
    check("rst_blank", 32'(blank), 1);
    check("rst_val", 32'(dig_val), 0);
    check("rst_sel", 32'(dig_sel), 0);
    check("rst_fd", 32'(frame_done), 0);
    run(41);

    // random requests, data and occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 4) req0 = ~req0;
      if ($urandom_range(0, 99) < 4) req1 = ~req1;
      if ($urandom_range(0, 99) < 6)
        data0 = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 300));
      if ($urandom_range(0, 99) < 6)
        data1 = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 300));
      rst = ($urandom_range(0, 999) < 2);
      tick();
    end
    rst = 1'b0;
    run(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
